// File: rtl/branch_cond_unit_pkg.sv
// Shared encodings for the branch condition unit: transfer kinds, Z80 condition
// codes, flag bit positions and the sequencing states.
package branch_cond_unit_pkg;

    localparam logic [1:0] KIND_ABS  = 2'd0;
    localparam logic [1:0] KIND_REL  = 2'd1;
    localparam logic [1:0] KIND_DJNZ = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    localparam logic [2:0] CC_NZ = 3'd0;
    localparam logic [2:0] CC_Z  = 3'd1;
    localparam logic [2:0] CC_NC = 3'd2;
    localparam logic [2:0] CC_C  = 3'd3;
    localparam logic [2:0] CC_PO = 3'd4;
    localparam logic [2:0] CC_PE = 3'd5;
    localparam logic [2:0] CC_P  = 3'd6;
    localparam logic [2:0] CC_M  = 3'd7;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_PV = 2;
    localparam int FLAG_C  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_ADD_LO,
        ST_ADD_HI,
        ST_DONE
    } stateT;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational Z80 condition evaluator (Cc, Uncond, F -> Cond); also used by
// the decoder prefetch logic, so it carries no kind-specific behaviour.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [2:0] Cc,
    input  logic       Uncond,
    input  logic [7:0] F,
    output logic       Cond
);

    logic flagTrue;
    logic unusedFlags;

    // Only S, Z, PV and C take part in any condition.
    assign unusedFlags = ^{F[5:3], F[1]};

    always_comb begin
        // NOTE: default assigned first so every path drives flagTrue and no latch is inferred.
        flagTrue = 1'b0;
        case (Cc)
            CC_NZ: flagTrue = !F[FLAG_Z];
            CC_Z:  flagTrue =  F[FLAG_Z];
            CC_NC: flagTrue = !F[FLAG_C];
            CC_C:  flagTrue =  F[FLAG_C];
            CC_PO: flagTrue = !F[FLAG_PV];
            CC_PE: flagTrue =  F[FLAG_PV];
            CC_P:  flagTrue = !F[FLAG_S];
            CC_M:  flagTrue =  F[FLAG_S];
        endcase
    end

    assign Cond = Uncond || flagTrue;

endmodule

// File: rtl/branch_cond_unit.sv
// Conditional control-transfer decision and target generation for JP/CALL/RET cc,
// JR cc and DJNZ. Define DJNZ_EN to build the DJNZ decrement/zero-test path.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Kind,
    input  logic        Uncond,
    input  logic [2:0]  Cc,
    input  logic [7:0]  F,
    input  logic [15:0] Pc,
    input  logic [7:0]  Disp,
    input  logic [15:0] Addr,
    input  logic [7:0]  BIn,
    output logic        Busy,
    output logic        Done,
    output logic        Taken,
    output logic [15:0] Target,
    output logic [7:0]  BOut,
    output logic        BWrite
);

    stateT       stateQ, stateD;
    logic [1:0]  kindQ;
    logic        uncondQ;
    logic [2:0]  ccQ;
    logic [7:0]  fQ;
    logic [15:0] pcQ;
    logic [7:0]  dispQ;
    logic [15:0] addrQ;
    logic        carryQ;
    logic        takenQ;
    logic [15:0] targetQ;
    logic [2:0]  ccEff;
    logic        condRaw;
    logic        takeNow;
    logic        isDjnz;
    logic        needsAdd;

`ifdef DJNZ_EN
    logic [7:0] bInQ;
    logic [7:0] bOutQ;
    logic [7:0] decValue;

    assign decValue = bInQ - 8'd1;
    assign isDjnz   = (kindQ == KIND_DJNZ);
    assign BOut     = bOutQ;
    assign BWrite   = (stateQ == ST_DONE) && isDjnz;
`else
    logic unusedBIn;

    assign unusedBIn = ^BIn;
    assign isDjnz    = 1'b0;
    assign BOut      = 8'h00;
    assign BWrite    = 1'b0;
`endif

    // JR only has the four Z/C conditions, so the PV/S half of Cc is masked off.
    assign ccEff = (kindQ == KIND_REL) ? {1'b0, ccQ[1:0]} : ccQ;

    cond_eval uCondEval (
        .Cc     (ccEff),
        .Uncond (uncondQ),
        .F      (fQ),
        .Cond   (condRaw)
    );

    always_comb begin
        takeNow = 1'b0;
        case (kindQ)
            KIND_ABS, KIND_REL: takeNow = condRaw;
`ifdef DJNZ_EN
            KIND_DJNZ:          takeNow = (decValue != 8'h00);
`endif
            default:            takeNow = 1'b0;
        endcase
    end

    assign needsAdd = takeNow && ((kindQ == KIND_REL) || isDjnz);

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (Reset) stateQ <= ST_IDLE;
        else       stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_IDLE:   if (Start) stateD = ST_EVAL;
            ST_EVAL:   stateD = needsAdd ? ST_ADD_LO : ST_DONE;
            ST_ADD_LO: stateD = ST_ADD_HI;
            ST_ADD_HI: stateD = ST_DONE;
            ST_DONE:   stateD = ST_IDLE;
            default:   stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kindQ   <= KIND_ABS;
            uncondQ <= 1'b0;
            ccQ     <= 3'd0;
            fQ      <= 8'h00;
            pcQ     <= 16'h0000;
            dispQ   <= 8'h00;
            addrQ   <= 16'h0000;
            carryQ  <= 1'b0;
            takenQ  <= 1'b0;
            targetQ <= 16'h0000;
`ifdef DJNZ_EN
            bInQ    <= 8'h00;
            bOutQ   <= 8'h00;
`endif
        end else begin
            case (stateQ)
                ST_IDLE: if (Start) begin
                    kindQ   <= Kind;
                    uncondQ <= Uncond;
                    ccQ     <= Cc;
                    fQ      <= F;
                    pcQ     <= Pc;
                    dispQ   <= Disp;
                    addrQ   <= Addr;
`ifdef DJNZ_EN
                    bInQ    <= BIn;
`endif
                end
                ST_EVAL: begin
                    takenQ <= takeNow;
                    if (takeNow && (kindQ == KIND_ABS)) targetQ <= addrQ;
`ifdef DJNZ_EN
                    if (isDjnz) bOutQ <= decValue;
`endif
                end
                // Low byte first; its carry feeds the sign-extended high-byte add.
                ST_ADD_LO: {carryQ, targetQ[7:0]} <= {1'b0, pcQ[7:0]} + {1'b0, dispQ};
                ST_ADD_HI: targetQ[15:8] <= pcQ[15:8] + {8{dispQ[7]}} + {7'd0, carryQ};
                default: ;
            endcase
        end
    end

    assign Busy   = (stateQ != ST_IDLE);
    assign Done   = (stateQ == ST_DONE);
    assign Taken  = takenQ;
    assign Target = targetQ;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed cases plus random requests
// compared against an arithmetic reference model.
module tb_branch_cond_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Kind;
    logic        Uncond;
    logic [2:0]  Cc;
    logic [7:0]  F;
    logic [15:0] Pc;
    logic [7:0]  Disp;
    logic [15:0] Addr;
    logic [7:0]  BIn;
    logic        Busy;
    logic        Done;
    logic        Taken;
    logic [15:0] Target;
    logic [7:0]  BOut;
    logic        BWrite;

    int assertCount = 0;
    int failCount   = 0;

`ifdef DJNZ_EN
    localparam bit DJNZ_ON = 1'b1;
`else
    localparam bit DJNZ_ON = 1'b0;
`endif

    logic        expTaken  = 1'b0;
    logic [15:0] expTarget = 16'h0000;
    logic [7:0]  expBOut   = 8'h00;
    logic        expBWrite = 1'b0;
    int          expLat    = 2;

    branch_cond_unit dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Kind   (Kind),
        .Uncond (Uncond),
        .Cc     (Cc),
        .F      (F),
        .Pc     (Pc),
        .Disp   (Disp),
        .Addr   (Addr),
        .BIn    (BIn),
        .Busy   (Busy),
        .Done   (Done),
        .Taken  (Taken),
        .Target (Target),
        .BOut   (BOut),
        .BWrite (BWrite)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit flagCond(input int c, input logic [7:0] f);
        case (c)
            0: return !f[6];
            1: return  f[6];
            2: return !f[0];
            3: return  f[0];
            4: return !f[2];
            5: return  f[2];
            6: return !f[7];
            default: return f[7];
        endcase
    endfunction

    // Updates the expected outputs; held values carry over from the previous request.
    task automatic model(input logic [1:0] k, input logic u, input logic [2:0] c,
                         input logic [7:0] f, input logic [15:0] pc, input logic [7:0] disp,
                         input logic [15:0] addr, input logic [7:0] bin);
        bit isAbs, isRel, isDj;
        int sd, dec;
        isAbs = (k == 2'd0);
        isRel = (k == 2'd1);
        isDj  = DJNZ_ON && (k == 2'd2);
        dec   = (int'(bin) + 255) % 256;
        if (isAbs)      expTaken = u || flagCond(int'(c), f);
        else if (isRel) expTaken = u || flagCond(int'(c) % 4, f);
        else if (isDj)  expTaken = (dec != 0);
        else            expTaken = 1'b0;
        sd = int'(disp);
        if (sd > 127) sd -= 256;
        if (expTaken && isAbs) expTarget = addr;
        if (expTaken && (isRel || isDj)) expTarget = 16'((int'(pc) + sd + 65536) % 65536);
        if (isDj) expBOut = 8'(dec);
        expBWrite = isDj;
        expLat    = (expTaken && (isRel || isDj)) ? 4 : 2;
    endtask

    task automatic drive(input logic [1:0] k, input logic u, input logic [2:0] c,
                         input logic [7:0] f, input logic [15:0] pc, input logic [7:0] disp,
                         input logic [15:0] addr, input logic [7:0] bin);
        Kind = k; Uncond = u; Cc = c; F = f; Pc = pc; Disp = disp; Addr = addr; BIn = bin;
    endtask

    // Presents one request at a falling edge, scrambles inputs after acceptance and checks the result.
    task automatic doReq(input string tag, input logic [1:0] k, input logic u, input logic [2:0] c,
                         input logic [7:0] f, input logic [15:0] pc, input logic [7:0] disp,
                         input logic [15:0] addr, input logic [7:0] bin);
        int lat;
        model(k, u, c, f, pc, disp, addr, bin);
        drive(k, u, c, f, pc, disp, addr, bin);
        Start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (i == 1) begin
                Start = 1'b0;
                drive(~k, ~u, ~c, ~f, ~pc, ~disp, ~addr, ~bin);
                check({tag, "_busy"}, 32'(Busy), 32'd1);
            end
            if (Done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        check({tag, "_taken"}, 32'(Taken), 32'(expTaken));
        check({tag, "_target"}, 32'(Target), 32'(expTarget));
        check({tag, "_bout"}, 32'(BOut), 32'(expBOut));
        check({tag, "_bwrite"}, 32'(BWrite), 32'(expBWrite));
        @(posedge Clk);
        @(negedge Clk);
        check({tag, "_idle"}, 32'({Busy, Done, BWrite}), 32'd0);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_ctl"}, 32'({Busy, Done, Taken, BWrite}), 32'd0);
        check({tag, "_target"}, 32'(Target), 32'h0000);
        check({tag, "_bout"}, 32'(BOut), 32'h00);
    endtask

    task automatic heldStart(input string tag, input logic [1:0] k, input logic u,
                             input logic [15:0] pc, input logic [7:0] disp, input int expDone);
        int doneCount;
        doneCount = 0;
        model(k, u, 3'd1, 8'h40, pc, disp, 16'h2222, 8'h05);
        drive(k, u, 3'd1, 8'h40, pc, disp, 16'h2222, 8'h05);
        Start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done === 1'b1) doneCount++;
        end
        Start = 1'b0;
        for (int i = 0; i < 10 && Busy !== 1'b0; i++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        check({tag, "_dones"}, 32'(doneCount), 32'(expDone));
        check({tag, "_drained"}, 32'(Busy), 32'd0);
        check({tag, "_target"}, 32'(Target), 32'(expTarget));
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        drive(2'd0, 1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, 16'h0000, 8'h00);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkZero("reset");
        Reset = 1'b0;

        doReq("abs_z_taken", 2'd0, 1'b0, 3'd1, 8'h40, 16'h0100, 8'h00, 16'h1234, 8'h00);
        doReq("abs_z_not",   2'd0, 1'b0, 3'd1, 8'h00, 16'h0100, 8'h00, 16'h5678, 8'h00);
        doReq("rel_cc7",     2'd1, 1'b0, 3'd7, 8'h01, 16'h10F0, 8'h20, 16'h0000, 8'h00);
        doReq("rel_back",    2'd1, 1'b1, 3'd0, 8'h00, 16'h0005, 8'hF0, 16'h0000, 8'h00);
        doReq("rel_wrap",    2'd1, 1'b1, 3'd0, 8'h00, 16'hFFFF, 8'h01, 16'h0000, 8'h00);
        doReq("rel_not",     2'd1, 1'b0, 3'd4, 8'h40, 16'h3000, 8'h10, 16'h0000, 8'h00);
        doReq("abs_m",       2'd0, 1'b0, 3'd7, 8'h80, 16'h0000, 8'h00, 16'hBEEF, 8'h00);
        doReq("djnz_one",    2'd2, 1'b1, 3'd1, 8'h40, 16'h0200, 8'hFE, 16'h0000, 8'h01);
        doReq("djnz_zero",   2'd2, 1'b0, 3'd0, 8'h00, 16'h0200, 8'hFE, 16'h0000, 8'h00);
        doReq("kind_rsvd",   2'd3, 1'b1, 3'd0, 8'hFF, 16'h4000, 8'h10, 16'h9999, 8'h10);

        heldStart("held_short", 2'd0, 1'b0, 16'h0000, 8'h00, 4);
        heldStart("held_long",  2'd1, 1'b1, 16'h0100, 8'h10, 2);

        // Reset while the low-byte add is in flight.
        drive(2'd1, 1'b1, 3'd0, 8'h00, 16'h1234, 8'h40, 16'h0000, 8'h00);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkZero("reset_add_lo");
        Reset = 1'b0;
        expTarget = 16'h0000;
        expBOut   = 8'h00;
        doReq("after_reset", 2'd0, 1'b0, 3'd6, 8'h00, 16'h0000, 8'h00, 16'h0F0F, 8'h00);

        for (int n = 0; n < 40; n++) begin
            doReq("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom),
                  8'($urandom), 16'($urandom), 8'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

- Reads the flag register and decides whether a conditional control transfer is taken.
- Covers JP/CALL/RET cc (absolute), JR cc (relative) and DJNZ.
- For relative kinds, computes the target as two serialized 8-bit additions, matching the byte-wide datapath.
- Sits between the flag register output and the PC load logic in the execute stage.

## Interface
Parameters:
- none.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request strobe; accepted only when Busy=0
- Kind  in  2  0=ABS (JP/CALL/RET), 1=REL (JR), 2=DJNZ, 3=reserved
- Uncond  in  1  1 = ignore Cc, condition true
- Cc  in  3  Z80 condition code: 0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M
- F  in  8  flag register: S=F[7], Z=F[6], PV=F[2], C=F[0]
- Pc  in  16  address of the next instruction (relative base)
- Disp  in  8  signed displacement (REL/DJNZ)
- Addr  in  16  absolute target (ABS)
- BIn  in  8  B register value (DJNZ)
- Busy  out  1  high from the cycle after acceptance until Done
- Done  out  1  one-cycle completion pulse
- Taken  out  1  decision; valid while Done=1, held until next acceptance
- Target  out  16  branch target; valid while Done=1 and Taken=1, held
- BOut  out  8  BIn-1 mod 256 (DJNZ)
- BWrite  out  1  one-cycle pulse coincident with Done, for DJNZ only

## Operation
Start is accepted when Busy=0. On acceptance, Kind, Uncond, Cc, Pc, Disp, Addr and BIn are captured, along with F as sampled in that same cycle. Later changes to these inputs have no effect.

States:
- IDLE: Busy=0. On Start, go to EVAL.
- EVAL: evaluate the condition, store Taken, then branch:
  - ABS, or not taken: go to DONE.
  - REL or DJNZ, and taken: go to ADD_LO.
- ADD_LO: Target[7:0] = Pc[7:0] + Disp; latch the carry-out.
- ADD_HI: Target[15:8] = Pc[15:8] + {8{Disp[7]}} + carry; go to DONE.
- DONE: Done=1, then go to IDLE.

Condition rules:
- cond = Uncond ? 1 : f(Cc, captured F), where:
  - NZ = !Z, Z = Z, NC = !C, C = C
  - PO = !PV, PE = PV, P = !S, M = S
- REL: only Cc[1:0] is used; Cc[2] is forced to 0.
- DJNZ: Cc and Uncond are ignored. BOut = BIn-1; Taken = (BOut != 0). BIn=0x01 is not taken; BIn=0x00 wraps to 0xFF and is taken.
- ABS: Target = captured Addr, loaded in EVAL.
- Kind=3: Taken=0, no BWrite.

Other rules:
- Target, Taken and BOut hold their values until the next acceptance.
- When not taken, Target is unchanged.
- Relative arithmetic is modulo 2^16: Pc=0xFFFF, Disp=0x01 gives 0x0000.
- Start while Busy=1 is ignored; it is neither queued nor errored.
- Start in the DONE cycle is ignored; the earliest re-accept is the following IDLE cycle.
- F is never written by this block.

## Timing
- Reset (including mid-operation) takes state to IDLE on the next edge. All outputs are zero: Busy, Done, Taken, BWrite, Target=0x0000, BOut=0x00.
- Start accepted at edge 0 → EVAL at edge 1.
- ABS, not-taken and Kind=3: Done high after edge 2 (latency 2).
- REL/DJNZ taken: ADD_LO at edge 2, ADD_HI at edge 3, Done high after edge 4 (latency 4).
- Back-to-back throughput: one request per 3 cycles (short) or 5 cycles (long).
- Busy is high in EVAL, ADD_LO, ADD_HI and DONE.

## Configuration
- DJNZ_EN defined: Kind=2 behaves as above.
- DJNZ_EN undefined:
  - Kind=2 behaves as Kind=3 (not taken, latency 2).
  - BWrite is tied to 0 and BOut is tied to 0x00.
  - No decrement or zero-test logic is synthesized.

## Structure
Shared package holds:
- Kind encodings: KIND_ABS, KIND_REL, KIND_DJNZ, KIND_RSVD.
- Cc encodings: CC_NZ … CC_M.
- Flag bit indices: FLAG_S=7, FLAG_Z=6, FLAG_PV=2, FLAG_C=0.
- State enum: ST_IDLE, ST_EVAL, ST_ADD_LO, ST_ADD_HI, ST_DONE.

Sub-module:
- One combinational sub-module, cond_eval (Cc, Uncond, F → cond), reused by the decoder's prefetch logic.
- The FSM and the 8-bit adder stay in the top.

## Test plan
- ABS, Cc=1 (Z), F=0x40, Addr=0x1234: Done at edge 2, Taken=1, Target=0x1234. Repeat with F=0x00: Taken=0, Target unchanged.
- REL, Cc=7 (treated as C), F=0x01, Pc=0x10F0, Disp=0x20: Done at edge 4, Taken=1, Target=0x1110 (carry into high byte).
- REL, Uncond=1, Pc=0x0005, Disp=0xF0: Target=0xFFF5. REL with Pc=0xFFFF, Disp=0x01: Target=0x0000.
- DJNZ (DJNZ_EN defined):
  - BIn=0x01 → Taken=0, BOut=0x00, BWrite pulses with Done at edge 2.
  - BIn=0x00 → Taken=1, BOut=0xFF, Done at edge 4.
- Start held high continuously: exactly one accept per 3-cycle/5-cycle window. Change F during EVAL: decision still uses the F captured at acceptance.
- Reset asserted in ADD_LO: next cycle all outputs are zero and state is IDLE. A Start on the cycle after reset deasserts is accepted normally.
